// File: rtl/aer_pkg.sv
// aer_pkg: state encoding, symbol codes and channel/polarity constants shared by both ends of the AER link
package aer_pkg;

   typedef enum logic [2:0] {IDLE, ACK0, WAIT1, ACK1, DRAIN} state_e;

   localparam logic [1:0] SYM_SPACER  = 2'b00;
   localparam logic [1:0] SYM_ZERO    = 2'b01;
   localparam logic [1:0] SYM_ONE     = 2'b10;
   localparam logic [1:0] SYM_ILLEGAL = 2'b11;

   localparam logic CH1      = 1'b0;
   localparam logic CH2      = 1'b1;
   localparam logic POL_UP   = 1'b0;
   localparam logic POL_DOWN = 1'b1;

   function automatic logic is_data(input logic [1:0] sym);
      return sym == SYM_ZERO || sym == SYM_ONE;
   endfunction

endpackage

// File: rtl/aer_sync2.sv
// aer_sync2: two-flop synchroniser for one asynchronous rail
module aer_sync2 (
   input  logic clk,
   input  logic reset,
   input  logic d_i,
   output logic q_o
);

   logic meta_q, sync_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         meta_q <= 1'b0;
         sync_q <= 1'b0;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/aer_receiver.sv
// aer_receiver: four-phase dual-rail AER receiver turning symbol pairs into per-channel event strobes
module aer_receiver
   import aer_pkg::*;
#(
   parameter int TIMEOUT = 1023,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             bit0,
   input  logic             bit1,
   output logic             ack,
   output logic             Ch1Up_Out,
   output logic             Ch1Down_Out,
   output logic             Ch2Up_Out,
   output logic             Ch2Down_Out,
   output logic             err,
   output logic [CNT_W-1:0] event_count
);

   localparam int TW = $clog2(TIMEOUT);

   logic [1:0]       sym;
   state_e           state_q, state_d;
   logic [TW-1:0]    timer_q, timer_d;
   logic             ch_q, ch_d;
   logic             ack_q, ack_d;
   logic             err_q, err_d;
   logic [3:0]       ev_q, ev_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             expire;

   aer_sync2 u_sync0 (.clk(clk), .reset(reset), .d_i(bit0), .q_o(sym[0]));
   aer_sync2 u_sync1 (.clk(clk), .reset(reset), .d_i(bit1), .q_o(sym[1]));

   assign expire = timer_q == TW'(TIMEOUT - 1);

   always_comb begin
      state_d = state_q;
      ch_d    = ch_q;
      ev_d    = '0;
      err_d   = 1'b0;
      cnt_d   = cnt_q;
      case (state_q)
         IDLE:
            if (is_data(sym)) begin
               ch_d    = sym == SYM_ONE;
               state_d = ACK0;
            end else if (sym == SYM_ILLEGAL) begin
               err_d   = 1'b1;
               state_d = DRAIN;
            end
         ACK0:
            if (sym == SYM_SPACER) state_d = WAIT1;
            else if (expire) begin
               err_d   = 1'b1;
               state_d = DRAIN;
            end
         WAIT1:
            if (is_data(sym)) begin
               // strobe index is {channel, polarity}: Ch1Up, Ch1Down, Ch2Up, Ch2Down
               ev_d    = 4'b0001 << {ch_q, sym == SYM_ONE};
               cnt_d   = cnt_q + 1'b1;
               state_d = ACK1;
            end else if (sym == SYM_ILLEGAL || expire) begin
               err_d   = 1'b1;
               state_d = DRAIN;
            end
         ACK1:
            if (sym == SYM_SPACER) state_d = IDLE;
            else if (expire) begin
               err_d   = 1'b1;
               state_d = DRAIN;
            end
         DRAIN:
            if (sym == SYM_SPACER) state_d = IDLE;
         default: state_d = IDLE;
      endcase
      timer_d = (state_d != state_q || !(state_q inside {ACK0, WAIT1, ACK1})) ? '0 : timer_q + 1'b1;
      ack_d   = state_d == ACK0 || state_d == ACK1;
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
         timer_q <= '0;
         ch_q    <= 1'b0;
         ack_q   <= 1'b0;
         err_q   <= 1'b0;
         ev_q    <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         timer_q <= timer_d;
         ch_q    <= ch_d;
         ack_q   <= ack_d;
         err_q   <= err_d;
         ev_q    <= ev_d;
         cnt_q   <= cnt_d;
      end
   end

   assign ack         = ack_q;
   assign err         = err_q;
   assign Ch1Up_Out   = ev_q[0];
   assign Ch1Down_Out = ev_q[1];
   assign Ch2Up_Out   = ev_q[2];
   assign Ch2Down_Out = ev_q[3];
   assign event_count = cnt_q;

endmodule

// File: tb/tb_aer_receiver.sv
// tb_aer_receiver: four-phase sender model driving aer_receiver, with a scoreboard of expected strobes
module tb_aer_receiver;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       bit0 = 1'b0;
   logic       bit1 = 1'b0;
   logic       ack, err;
   logic       ch1u, ch1d, ch2u, ch2d;
   logic [3:0] event_count;

   aer_receiver #(.TIMEOUT(8), .CNT_W(4)) dut (
      .clk(clk), .reset(reset), .bit0(bit0), .bit1(bit1), .ack(ack),
      .Ch1Up_Out(ch1u), .Ch1Down_Out(ch1d), .Ch2Up_Out(ch2u), .Ch2Down_Out(ch2d),
      .err(err), .event_count(event_count)
   );

   always #5 clk = ~clk;

   // outs encoding: {err, Ch2Down, Ch2Up, Ch1Down, Ch1Up}
   typedef struct {
      logic [4:0] outs;
      logic [3:0] cnt;
   } exp_t;

   exp_t       q[$];
   int         n_vec = 0;
   int         n_bad = 0;
   int         ack_rises = 0;
   logic       ack_prev = 1'b0;
   logic [3:0] exp_cnt = '0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      logic [4:0] outs;
      exp_t e;
      outs = {err, ch2d, ch2u, ch1d, ch1u};
      if (ack && !ack_prev) ack_rises++;
      ack_prev = ack;
      if (outs != '0) begin
         chk("onehot", $countones(outs), 1);
         if (q.size() == 0) chk("unexpected_out", outs, 0);
         else begin
            e = q.pop_front();
            chk("strobe", outs, e.outs);
            chk("count", event_count, e.cnt);
         end
      end
   end

   task automatic wait_ack(input logic lvl);
      int n = 0;
      while (ack !== lvl && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ack !== lvl) chk("ack_timeout", ack, lvl);
   endtask

   task automatic send_sym(input logic b);
      @(negedge clk);
      {bit1, bit0} = b ? 2'b10 : 2'b01;
      wait_ack(1'b1);
      {bit1, bit0} = 2'b00;
      wait_ack(1'b0);
   endtask

   task automatic send_event(input logic ch, input logic pol);
      exp_cnt++;
      q.push_back('{5'b00001 << {ch, pol}, exp_cnt});
      send_sym(ch);
      send_sym(pol);
   endtask

   initial begin
      int r;
      logic seen_ack;
      repeat (3) @(negedge clk);
      reset = 1'b0;
      @(negedge clk);
      chk("reset_outs", {ack, err, ch2d, ch2u, ch1d, ch1u}, 0);
      chk("reset_count", event_count, 0);
      r = ack_rises;
      send_event(1'b1, 1'b1);
      chk("ack_pulses", ack_rises - r, 2);
      send_event(1'b0, 1'b0);
      send_event(1'b0, 1'b1);
      send_event(1'b1, 1'b0);
      send_event(1'b1, 1'b1);
      chk("b2b_count", event_count, 5);
      // both rails high while idle
      @(negedge clk);
      q.push_back('{5'b10000, exp_cnt});
      {bit1, bit0} = 2'b11;
      seen_ack = 1'b0;
      repeat (10) begin
         @(negedge clk);
         seen_ack |= ack;
      end
      chk("illegal_ack", seen_ack, 0);
      {bit1, bit0} = 2'b00;
      repeat (5) @(negedge clk);
      send_event(1'b1, 1'b0);
      // first symbol then sender stalls
      q.push_back('{5'b10000, exp_cnt});
      send_sym(1'b0);
      repeat (20) @(negedge clk);
      chk("timeout_count", event_count, exp_cnt);
      chk("timeout_err_seen", q.size(), 0);
      // reset while in ACK0
      @(negedge clk);
      {bit1, bit0} = 2'b10;
      wait_ack(1'b1);
      reset = 1'b1;
      {bit1, bit0} = 2'b00;
      @(negedge clk);
      chk("rst_ack", ack, 0);
      chk("rst_outs", {err, ch2d, ch2u, ch1d, ch1u}, 0);
      reset = 1'b0;
      exp_cnt = '0;
      chk("rst_count", event_count, 0);
      repeat (5) @(negedge clk);
      send_event(1'b0, 1'b1);
      for (int i = 0; i < 16; i++) send_event(1'(i >> 1), 1'(i));
      repeat (5) @(negedge clk);
      chk("wrap_count", event_count, 1);
      chk("queue_empty", q.size(), 0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
